dc_pipe: RTL and testbench
==========================

// Module: dc_pipe
// PURPOSE
//  Parametrised, registered binary-to-positional decoder with valid/ready handshake.
//  Maps IN_W-bit code to OUT_W-bit one-hot or thermometer word; flags out-of-range codes.
//  Two-entry skid buffer on output: full throughput, registered inReady, 1-cycle latency.
//  Drop-in for channel/bank select paths where the consumer can stall.
// PARAMETERS
//  IN_W       3   input code width, 1..6
//  OUT_W      8   output width, 2..2**IN_W; codes >= OUT_W are out of range
//  ACTIVE_LOW 0   1: outData bit-inverted (idle/reset word all ones)
//  CNT_W      16  statistics counter width (DC_PIPE_STATS_EN only)
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous reset, active high
//  inData    in   IN_W   binary code
//  inMode    in   1      0 one-hot, 1 thermometer; sampled with the beat
//  inValid   in   1      input beat valid
//  inReady   out  1      input accept; registered
//  outData   out  OUT_W  decoded word
//  outErr    out  1      beat had code >= OUT_W; qualified by outValid
//  outValid  out  1      output beat valid
//  outReady  in   1      consumer accept
// BEHAVIOUR
//  - Reset (async assert, sync release): outValid=0, outErr=0, inReady=1,
//    outData = ACTIVE_LOW ? all ones : all zeros; skid register empty.
//  - Input handshake: inValid&inReady. Output handshake: outValid&outReady.
//  - Decode of code c, pre-inversion: one-hot bit[c]=1, others 0;
//    thermometer bits[c:0]=1, others 0. c>=OUT_W: word all zeros, outErr=1.
//  - Latency: a beat accepted at edge N is presented at outValid after edge N.
//  - States: EMPTY (main empty), ONE (main full), TWO (main+skid full).
//    EMPTY: accept -> ONE.
//    ONE: accept & out handshake -> ONE (main reloaded);
//         accept & no out handshake -> TWO (beat to skid, inReady=0 next cycle);
//         out handshake only -> EMPTY.
//    TWO: inReady=0; out handshake -> ONE (skid moves to main, inReady=1 next cycle).
//  - Input accepted only while inReady=1; inValid ignored while inReady=0.
//  - Held output: outData/outErr stable while outValid&!outReady.
//  - Strict order, no drops, no duplicates. Throughput 1 beat/cycle when outReady=1.
//  - outValid=0: outData holds last value, outErr holds last value; neither is checked.
//  - rst mid-transfer: both entries discarded, reset values next cycle.
// CONFIGURATION
//  DC_PIPE_STATS_EN defined: adds statClr (in,1), beatCnt (out,CNT_W), errCnt (out,CNT_W).
//    beatCnt +1 per output handshake; errCnt +1 per output handshake with outErr=1.
//    Both saturate at all ones. statClr: sync clear to 0, wins over increment. Reset 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Default params, outReady=1, codes 0..7 one-hot on back-to-back cycles
//     -> outData 01,02,04,..,80 one cycle later, one beat/cycle, inReady stays 1.
//  2. inMode=1, code 3 -> outData 8'b0000_1111; code 0 -> 8'b0000_0001.
//  3. OUT_W=6, codes 5,6,7 -> 6'b100000 outErr=0; then 000000 outErr=1, twice.
//  4. outReady=0 while codes 1,2 sent -> TWO, inReady=0; outReady=1 -> 02 then 04,
//     inReady=1 the cycle after leaving TWO; random stall run vs. queue model, no loss.
//  5. ACTIVE_LOW=1: reset -> outData all ones; code 2 -> 8'b1111_1011.
//  6. rst pulse in TWO -> outValid=0, inReady=1 same cycle; stats on: 3 beats incl.
//     1 error -> beatCnt=3, errCnt=1; statClr with handshake -> 0.

Source files
------------

// File: rtl/dc_pipe.sv
// dc_pipe: registered binary-to-one-hot/thermometer decoder with a two-entry skid output stage.
// Optional statistics counters are enabled by defining DC_PIPE_STATS_EN.
module dc_pipe #(
  parameter int IN_W       = 3,
  parameter int OUT_W      = 8,
  parameter int ACTIVE_LOW = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   inData,
  input  logic              inMode,
  input  logic              inValid,
  output logic              inReady,
  output logic [OUT_W-1:0]  outData,
  output logic              outErr,
  output logic              outValid,
  input  logic              outReady
`ifdef DC_PIPE_STATS_EN
  ,
  input  logic              statClr,
  output logic [CNT_W-1:0]  beatCnt,
  output logic [CNT_W-1:0]  errCnt
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  localparam logic [OUT_W-1:0] IDLE_WORD = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_in_ready;
  logic [OUT_W-1:0]   r_main_data;
  logic               r_main_err;
  logic [OUT_W-1:0]   r_skid_data;
  logic               r_skid_err;

  logic               w_acc;
  logic               w_ohs;
  logic               w_load_main;
  logic               w_main_from_skid;
  logic               w_load_skid;
  logic [OUT_W:0]     w_dec;

  // Returns {err, word}; out-of-range codes give an all-zero word before inversion.
  function automatic logic [OUT_W:0] f_decode(input logic [IN_W-1:0] code, input logic mode);
    logic [OUT_W-1:0] word;
    logic             err;
    word = '0;
    err  = (int'(code) >= OUT_W);
    for (int i = 0; i < OUT_W; i++) begin
      if (!err) begin
        word[i] = mode ? (i <= int'(code)) : (i == int'(code));
      end
    end
    if (ACTIVE_LOW != 0) begin
      word = ~word;
    end
    return {err, word};
  endfunction

  assign w_dec    = f_decode(inData, inMode);
  assign outValid = (r_state != S_EMPTY);
  assign inReady  = r_in_ready;
  assign outData  = r_main_data;
  assign outErr   = r_main_err;
  assign w_acc    = inValid & r_in_ready;
  assign w_ohs    = outValid & outReady;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_ohs) begin
          w_load_main = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_ohs) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_ohs) begin
          w_state_nxt      = S_ONE;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= IDLE_WORD;
      r_main_err  <= 1'b0;
      r_skid_data <= IDLE_WORD;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_load_main) begin
        if (w_main_from_skid) begin
          r_main_data <= r_skid_data;
          r_main_err  <= r_skid_err;
        end else begin
          r_main_data <= w_dec[OUT_W-1:0];
          r_main_err  <= w_dec[OUT_W];
        end
      end
      if (w_load_skid) begin
        r_skid_data <= w_dec[OUT_W-1:0];
        r_skid_err  <= w_dec[OUT_W];
      end
    end
  end

`ifdef DC_PIPE_STATS_EN
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  // Saturating counters; a synchronous clear overrides any increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (statClr) begin
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_ohs) begin
      if (r_beat_cnt != {CNT_W{1'b1}}) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (r_main_err && (r_err_cnt != {CNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign beatCnt = r_beat_cnt;
  assign errCnt  = r_err_cnt;
`endif

endmodule

// File: tb/tb_dc_pipe.sv
// Self-checking bench for dc_pipe: scoreboarded default instance plus directed
// checks on an OUT_W=6 instance and an ACTIVE_LOW=1 instance.
module tb_dc_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] a_data;
  logic       a_mode, a_valid, a_ordy;
  wire        a_irdy, a_err, a_ov;
  wire  [7:0] a_out;

  logic [2:0] b_data;
  logic       b_mode, b_valid, b_ordy, b_clr;
  wire        b6_irdy, b6_err, b6_ov;
  wire  [5:0] b6_out;
  wire        bl_irdy, bl_err, bl_ov;
  wire  [7:0] bl_out;

`ifdef DC_PIPE_STATS_EN
  wire [15:0] a_bc, a_ec, b6_bc, b6_ec, bl_bc, bl_ec;
`endif

  dc_pipe u_dut (
    .clk(clk), .rst(rst), .inData(a_data), .inMode(a_mode), .inValid(a_valid),
    .inReady(a_irdy), .outData(a_out), .outErr(a_err), .outValid(a_ov), .outReady(a_ordy)
`ifdef DC_PIPE_STATS_EN
    , .statClr(1'b0), .beatCnt(a_bc), .errCnt(a_ec)
`endif
  );

  dc_pipe #(.OUT_W(6)) u_dut6 (
    .clk(clk), .rst(rst), .inData(b_data), .inMode(b_mode), .inValid(b_valid),
    .inReady(b6_irdy), .outData(b6_out), .outErr(b6_err), .outValid(b6_ov), .outReady(b_ordy)
`ifdef DC_PIPE_STATS_EN
    , .statClr(b_clr), .beatCnt(b6_bc), .errCnt(b6_ec)
`endif
  );

  dc_pipe #(.ACTIVE_LOW(1)) u_dutl (
    .clk(clk), .rst(rst), .inData(b_data), .inMode(b_mode), .inValid(b_valid),
    .inReady(bl_irdy), .outData(bl_out), .outErr(bl_err), .outValid(bl_ov), .outReady(b_ordy)
`ifdef DC_PIPE_STATS_EN
    , .statClr(b_clr), .beatCnt(bl_bc), .errCnt(bl_ec)
`endif
  );

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];

  function automatic exp_t model(int code, bit mode, int outw, bit al);
    logic [63:0] w;
    exp_t        r;
    if (code >= outw) begin
      w   = 64'd0;
      r.e = 1'b1;
    end else begin
      r.e = 1'b0;
      w   = mode ? ((64'd2 << code) - 64'd1) : (64'd1 << code);
    end
    if (al) w = ~w;
    r.d = w[7:0];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on input handshake, pop on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_ov && a_ordy) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL sb_extra: observed beat %0h expected none", a_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_data", 64'(a_out), 64'(e.d));
          chk("sb_err", 64'(a_err), 64'(e.e));
          pops++;
        end
      end
      if (a_valid && a_irdy) q.push_back(model(int'(a_data), a_mode, 8, 1'b0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic a_step(input logic v, input logic [2:0] code, input logic mode, input logic ordy);
    @(posedge clk);
    #1;
    a_valid = v;
    a_data  = code;
    a_mode  = mode;
    a_ordy  = ordy;
  endtask

  task automatic b_beat(input logic [2:0] code, input logic mode);
    @(posedge clk);
    #1;
    b_valid = 1'b1;
    b_data  = code;
    b_mode  = mode;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic b_check(input string tag, input int code, input bit mode);
    exp_t m6, ml;
    m6 = model(code, mode, 6, 1'b0);
    ml = model(code, mode, 8, 1'b1);
    chk({tag, "_d6"}, 64'(b6_out), 64'(m6.d[5:0]));
    chk({tag, "_e6"}, 64'(b6_err), 64'(m6.e));
    chk({tag, "_dl"}, 64'(bl_out), 64'(ml.d));
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_mode = 1'b0; a_valid = 1'b0; a_ordy = 1'b1;
    b_data = '0; b_mode = 1'b0; b_valid = 1'b0; b_ordy = 1'b1; b_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ov", 64'(a_ov), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_irdy", 64'(a_irdy), 64'd1);
    chk("rst_out", 64'(a_out), 64'h00);
    chk("rst_out_al", 64'(bl_out), 64'hFF);

    // back-to-back one-hot codes
    for (int c = 0; c < 8; c++) begin
      a_step(1'b1, 3'(c), 1'b0, 1'b1);
      @(negedge clk);
      chk("t1_irdy", 64'(a_irdy), 64'd1);
      chk("t1_ov", 64'(a_ov), (c != 0) ? 64'd1 : 64'd0);
    end
    a_step(1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_last", 64'(a_out), 64'h80);
    a_step(1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_pops", 64'(pops), 64'd8);
    chk("t1_idle", 64'(a_ov), 64'd0);

    // thermometer
    a_step(1'b1, 3'd3, 1'b1, 1'b1);
    a_step(1'b1, 3'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_th3", 64'(a_out), 64'h0F);
    a_step(1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_th0", 64'(a_out), 64'h01);
    a_step(1'b0, 3'd0, 1'b0, 1'b1);

    // stall into TWO, then drain
    a_step(1'b1, 3'd1, 1'b0, 1'b0);
    a_step(1'b1, 3'd2, 1'b0, 1'b0);
    a_step(1'b1, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_two_irdy", 64'(a_irdy), 64'd0);
    chk("t4_two_ov", 64'(a_ov), 64'd1);
    chk("t4_hold", 64'(a_out), 64'h02);
    a_step(1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_still_two", 64'(a_irdy), 64'd0);
    a_step(1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_irdy_back", 64'(a_irdy), 64'd1);
    chk("t4_second", 64'(a_out), 64'h04);
    a_step(1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_empty", 64'(a_ov), 64'd0);
    chk("t4_q", 64'(q.size()), 64'd0);

    // random stalls against the queue model
    for (int i = 0; i < 400; i++) begin
      a_step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0));
    end
    a_step(1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      a_step(1'b0, 3'd0, 1'b0, 1'b1);
    end
    @(negedge clk);
    chk("rand_drain_q", 64'(q.size()), 64'd0);
    chk("rand_drain_ov", 64'(a_ov), 64'd0);

    // async reset while in TWO
    a_step(1'b1, 3'd4, 1'b0, 1'b0);
    a_step(1'b1, 3'd5, 1'b0, 1'b0);
    a_step(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_in_two", 64'(a_irdy), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ov", 64'(a_ov), 64'd0);
    chk("t6_rst_irdy", 64'(a_irdy), 64'd1);
    chk("t6_rst_out", 64'(a_out), 64'h00);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    pops = 0;
    a_step(1'b1, 3'd6, 1'b0, 1'b1);
    a_step(1'b0, 3'd0, 1'b0, 1'b1);
    a_step(1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_after_pops", 64'(pops), 64'd1);

    // OUT_W=6 range check and ACTIVE_LOW instance
    b_beat(3'd5, 1'b0);
    b_check("t3_c5", 5, 1'b0);
    chk("t3_c5_lit", 64'(b6_out), 64'h20);
    b_beat(3'd6, 1'b0);
    b_check("t3_c6", 6, 1'b0);
    chk("t3_c6_err", 64'(b6_err), 64'd1);
    b_beat(3'd7, 1'b0);
    b_check("t3_c7", 7, 1'b0);
    chk("t3_c7_lit", 64'(b6_out), 64'h00);
    b_beat(3'd2, 1'b0);
    b_check("t5_c2", 2, 1'b0);
    chk("t5_al_lit", 64'(bl_out), 64'hFB);
    @(posedge clk);
    #1;
    @(negedge clk);
`ifdef DC_PIPE_STATS_EN
    chk("st_beat4", 64'(b6_bc), 64'd4);
    chk("st_err2", 64'(b6_ec), 64'd2);
    b_clr = 1'b1;
    b_beat(3'd1, 1'b0);
    @(posedge clk);
    #1 b_clr = 1'b0;
    @(negedge clk);
    chk("st_clr_beat", 64'(b6_bc), 64'd0);
    chk("st_clr_err", 64'(b6_ec), 64'd0);
    b_beat(3'd6, 1'b0);
    b_beat(3'd1, 1'b0);
    b_beat(3'd2, 1'b1);
    b_check("st_th2", 2, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("st_beat3", 64'(b6_bc), 64'd3);
    chk("st_err1", 64'(b6_ec), 64'd1);
    b_clr = 1'b1;
    b_beat(3'd0, 1'b0);
    @(posedge clk);
    #1 b_clr = 1'b0;
    @(negedge clk);
    chk("st_clr2_beat", 64'(b6_bc), 64'd0);
    chk("st_clr2_err", 64'(b6_ec), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
